ef_sram_responder: RTL and testbench

//   Synthesizable SRAM-side responder for the EF_SRAM pin protocol (DI/BEN/AD/EN/R_WB -> DO).

---
 rtl/ef_sram_responder_if.sv | 24 ++
 rtl/ef_sram_responder.sv | 103 ++++++++++
 tb/tb_ef_sram_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ef_sram_responder_if.sv
// EF_SRAM pin bundle: write data, bit enables, address, strobe, direction and read data.
interface ef_sram_responder_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic [DW-1:0] DI_SRAM;
  logic [DW-1:0] BEN_SRAM;
  logic [AW-1:0] AD_SRAM;
  logic          EN_SRAM;
  logic          R_WB_SRAM;
  logic [DW-1:0] DO_SRAM;

  // Fabric side drives the request pins and receives read data.
  modport master (
    output DI_SRAM, BEN_SRAM, AD_SRAM, EN_SRAM, R_WB_SRAM,
    input  DO_SRAM
  );

  // Memory side receives requests and returns read data.
  modport slave (
    input  DI_SRAM, BEN_SRAM, AD_SRAM, EN_SRAM, R_WB_SRAM,
    output DO_SRAM
  );
endinterface

// File: rtl/ef_sram_responder.sv
// Behavioural SRAM responder for the EF_SRAM pin protocol with a whole-array
// clear sequencer, busy flag and sticky access-while-busy error flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | normal operation: reads, bit-masked writes, accepts clear_req
//   ST_CLEAR | writes CLEAR_VALUE to one word per cycle; accesses dropped
module ef_sram_responder #(
  parameter int            AW             = 10,
  parameter int            DW             = 32,
  parameter bit            CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  UserCLK,
  input  logic                  resetn,
  ef_sram_responder_if.slave    bus,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] do_q;
  logic [DW-1:0] mem [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  assign bus.DO_SRAM = do_q;

  // Single write port: the clear sequencer owns it in CLEAR, the bus in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.AD_SRAM;
    mem_wdata = (mem[bus.AD_SRAM] & ~bus.BEN_SRAM) | (bus.DI_SRAM & bus.BEN_SRAM);
    if (resetn) begin
      if (state == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = CLEAR_VALUE;
      end else if (bus.EN_SRAM && !bus.R_WB_SRAM) begin
        mem_we = 1'b1;
      end
    end
  end

  // Array storage; contents are deliberately untouched by reset.
  always_ff @(posedge UserCLK) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Sequencer FSM with registered read data, busy and sticky error.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      do_q     <= '0;
      err      <= 1'b0;
      clr_addr <= '0;
      state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      busy     <= CLEAR_ON_RESET;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.EN_SRAM && bus.R_WB_SRAM) begin
            do_q <= mem[bus.AD_SRAM];
          end
          if (clear_req) begin
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (bus.EN_SRAM) begin
            err <= 1'b1;
          end
          if (clr_addr == {AW{1'b1}}) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ef_sram_responder.sv
// Directed bench for ef_sram_responder: instance A clears on reset, instance B does not.
module tb_ef_sram_responder;

  logic clk = 1'b0;
  logic resetn_a = 1'b0;
  logic resetn_b = 1'b0;
  logic clear_req_a = 1'b0;
  logic clear_req_b = 1'b0;
  logic busy_a, err_a, busy_b, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  ef_sram_responder_if #(.AW(10), .DW(32)) a_if();
  ef_sram_responder_if #(.AW(10), .DW(32)) b_if();

  ef_sram_responder #(.AW(10), .DW(32), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h0)) dut_a (
    .UserCLK(clk), .resetn(resetn_a), .bus(a_if), .clear_req(clear_req_a),
    .busy(busy_a), .err(err_a)
  );

  ef_sram_responder #(.AW(10), .DW(32), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(32'h0)) dut_b (
    .UserCLK(clk), .resetn(resetn_b), .bus(b_if), .clear_req(clear_req_b),
    .busy(busy_b), .err(err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic en, input logic rwb,
                       input logic [9:0] ad, input logic [31:0] di, input logic [31:0] ben);
    if (!sel) begin
      a_if.EN_SRAM = en; a_if.R_WB_SRAM = rwb; a_if.AD_SRAM = ad;
      a_if.DI_SRAM = di; a_if.BEN_SRAM = ben;
    end else begin
      b_if.EN_SRAM = en; b_if.R_WB_SRAM = rwb; b_if.AD_SRAM = ad;
      b_if.DI_SRAM = di; b_if.BEN_SRAM = ben;
    end
  endtask

  task automatic wr(input bit sel, input logic [9:0] ad, input logic [31:0] di, input logic [31:0] ben);
    drive(sel, 1'b1, 1'b0, ad, di, ben);
    tick();
    drive(sel, 1'b0, 1'b1, 10'd0, 32'h0, 32'h0);
  endtask

  task automatic rd(input bit sel, input logic [9:0] ad, output logic [31:0] data);
    drive(sel, 1'b1, 1'b1, ad, 32'h0, 32'h0);
    tick();
    drive(sel, 1'b0, 1'b1, 10'd0, 32'h0, 32'h0);
    data = sel ? b_if.DO_SRAM : a_if.DO_SRAM;
  endtask

  // Counts edges until instance A drops busy; bounded so a stuck FSM still ends.
  task automatic wait_idle_a(inout int n);
    for (int i = 0; i < 3000; i++) begin
      if (!busy_a) return;
      tick();
      n++;
    end
  endtask

  logic [31:0] d;
  int          n;

  initial begin
    drive(1'b0, 1'b0, 1'b1, 10'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 10'd0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state
    chk("rst_do", a_if.DO_SRAM, 32'h0);
    chk("rst_err", {31'b0, err_a}, 32'h0);
    chk("rst_busy_a", {31'b0, busy_a}, 32'h1);
    chk("rst_busy_b", {31'b0, busy_b}, 32'h0);

    // T1: clear after reset release lasts exactly 1024 cycles
    resetn_a = 1'b1;
    resetn_b = 1'b1;
    n = 0;
    wait_idle_a(n);
    chk("t1_busy_cycles", n, 32'd1024);
    rd(1'b0, 10'd0, d);    chk("t1_rd0", d, 32'h0);
    rd(1'b0, 10'd511, d);  chk("t1_rd511", d, 32'h0);
    rd(1'b0, 10'd1023, d); chk("t1_rd1023", d, 32'h0);

    // T2: full write then read-after-write; DO holds through idle and writes
    wr(1'b0, 10'd5, 32'hDEADBEEF, 32'hFFFFFFFF);
    rd(1'b0, 10'd5, d);    chk("t2_rd5", d, 32'hDEADBEEF);
    tick(); tick(); tick();
    chk("t2_hold", a_if.DO_SRAM, 32'hDEADBEEF);
    wr(1'b0, 10'd6, 32'h01020304, 32'hFFFFFFFF);
    chk("t2_no_wthru", a_if.DO_SRAM, 32'hDEADBEEF);
    rd(1'b0, 10'd6, d);    chk("t2_rd6", d, 32'h01020304);

    // T3: low-half byte-enable write
    wr(1'b0, 10'd5, 32'h12345678, 32'h0000FFFF);
    rd(1'b0, 10'd5, d);    chk("t3_partial", d, 32'hDEAD5678);
    wr(1'b0, 10'd5, 32'h00FF0000, 32'h00F0F000);
    rd(1'b0, 10'd5, d);    chk("t3_mixed", d, 32'hDEFD0678);

    // T4: access during CLEAR is dropped and flags err; clear_req during CLEAR ignored
    wr(1'b0, 10'd7, 32'h11111111, 32'hFFFFFFFF);
    clear_req_a = 1'b1;
    tick();
    clear_req_a = 1'b0;
    chk("t4_busy", {31'b0, busy_a}, 32'h1);
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; end
    chk("t4_err_pre", {31'b0, err_a}, 32'h0);
    wr(1'b0, 10'd7, 32'hFFFFFFFF, 32'hFFFFFFFF); n++;
    chk("t4_err", {31'b0, err_a}, 32'h1);
    chk("t4_do_hold", a_if.DO_SRAM, 32'hDEFD0678);
    clear_req_a = 1'b1;
    tick(); n++;
    clear_req_a = 1'b0;
    wait_idle_a(n);
    chk("t4_busy_cycles", n, 32'd1024);
    chk("t4_err_sticky", {31'b0, err_a}, 32'h1);
    chk("t4_do_after", a_if.DO_SRAM, 32'hDEFD0678);
    rd(1'b0, 10'd7, d);    chk("t4_rd7", d, 32'h0);
    rd(1'b0, 10'd5, d);    chk("t4_rd5", d, 32'h0);

    // T5: clear_req together with a write; write lands, then gets cleared
    clear_req_a = 1'b1;
    wr(1'b0, 10'd9, 32'hA5A5A5A5, 32'hFFFFFFFF);
    clear_req_a = 1'b0;
    chk("t5_busy", {31'b0, busy_a}, 32'h1);
    n = 0;
    wait_idle_a(n);
    chk("t5_busy_cycles", n, 32'd1024);
    rd(1'b0, 10'd9, d);    chk("t5_rd9", d, 32'h0);
    wr(1'b0, 10'd9, 32'h0BADF00D, 32'hFFFFFFFF);
    rd(1'b0, 10'd9, d);    chk("t5_rd9_new", d, 32'h0BADF00D);

    // Reset clears err and restarts CLEAR on instance A
    resetn_a = 1'b0;
    tick();
    resetn_a = 1'b1;
    chk("rst2_err", {31'b0, err_a}, 32'h0);
    chk("rst2_do", a_if.DO_SRAM, 32'h0);
    chk("rst2_busy", {31'b0, busy_a}, 32'h1);

    // T6: reset aborts a clear on instance B (no clear on reset)
    wr(1'b1, 10'd50, 32'h50505050, 32'hFFFFFFFF);
    wr(1'b1, 10'd200, 32'hC8C8C8C8, 32'hFFFFFFFF);
    clear_req_b = 1'b1;
    tick();
    clear_req_b = 1'b0;
    chk("t6_busy", {31'b0, busy_b}, 32'h1);
    for (int i = 0; i < 100; i++) tick();
    resetn_b = 1'b0;
    tick();
    resetn_b = 1'b1;
    chk("t6_busy_rel", {31'b0, busy_b}, 32'h0);
    tick();
    chk("t6_busy_idle", {31'b0, busy_b}, 32'h0);
    rd(1'b1, 10'd50, d);   chk("t6_rd50", d, 32'h0);
    rd(1'b1, 10'd200, d);  chk("t6_rd200", d, 32'hC8C8C8C8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
